// File: rtl/sat_pkg.sv
// sat_pkg: shared types and constants for the unit clause write path.
package sat_pkg;
    localparam int W_VARS = 8;
    typedef enum logic [2:0] {IDLE, COLLECT, FLUSH, DRAIN, CONFLICT} uc_coll_state_t;
    typedef struct packed {
        logic [$clog2(W_VARS)-1:0] var_idx;
        logic                      pol;
    } lit_t;
endpackage

// File: rtl/uc_accum.sv
// uc_accum: per-batch literal accumulator (variable bitmap, polarity map, distinct count).
// Exposes next-state values so the FSM can flush the in_last beat on the same edge it is set.
module uc_accum
    import sat_pkg::*;
#(
    parameter int w = W_VARS,
    localparam int VW = $clog2(w)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set,
    input  logic          clr,
    input  logic [VW-1:0] var_idx,
    input  logic          pol,
    output logic [w-1:0]  map_nxt,
    output logic [w-1:0]  pols_nxt,
    output logic [VW:0]   cnt_nxt,
    output logic          dup,
    output logic          conf
);
    logic [w-1:0] map, pols, sel;
    logic [VW:0]  cnt;
    logic         in_rng, hit;
    // out-of-range indices select nothing, so they never hit, set or count
    assign in_rng   = {1'b0, var_idx} < (VW+1)'(w);
    assign sel      = in_rng ? {{(w-1){1'b0}}, 1'b1} << var_idx : '0;
    assign hit      = |(map & sel);
    assign dup      = hit && ((|(pols & sel)) == pol);
    assign conf     = hit && !dup;
    assign map_nxt  = set ? map | sel : map;
    assign pols_nxt = set ? (pols & ~sel) | (pol ? sel : '0) : pols;
    assign cnt_nxt  = cnt + (VW+1)'(set && in_rng && !hit);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            map  <= '0;
            pols <= '0;
            cnt  <= '0;
        end else if (clr) begin
            map  <= '0;
            pols <= '0;
            cnt  <= '0;
        end else begin
            map  <= map_nxt;
            pols <= pols_nxt;
            cnt  <= cnt_nxt;
        end
    end
endmodule

// File: rtl/unit_clause_collector.sv
// unit_clause_collector: packs a batch of implied unit literals into one write of the
// unit clause register, flags intra-batch conflicts, and waits for the register to drain.
module unit_clause_collector
    import sat_pkg::*;
#(
    parameter int w = W_VARS,
    localparam int VW = $clog2(w)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [VW-1:0] in_var,
    input  logic          in_pol,
    input  logic          in_last,
    input  logic          uc_empty,
    output logic          w_en,
    output logic [w-1:0]  wd,
    output logic [w-1:0]  pol_map,
    output logic [VW:0]   unit_cnt,
    output logic          conflict,
    input  logic          conflict_clr
);
    uc_coll_state_t state;
    logic           last_seen, clr_seen, conf_done;
    logic           xfer, collecting, acc_set, acc_clr, acc_dup, acc_conf;
    logic [w-1:0]   map_nxt, pols_nxt;
    logic [VW:0]    cnt_nxt;
    assign xfer       = in_valid && in_ready;
    assign collecting = state == IDLE || state == COLLECT;
    assign acc_set    = collecting && xfer && !acc_dup && !acc_conf;
    assign acc_clr    = collecting && xfer && (acc_conf || in_last);
    assign conf_done  = (last_seen || (xfer && in_last)) && (clr_seen || conflict_clr);
    uc_accum #(.w(w)) u_accum (
        .clk      (clk),
        .rst_n    (rst_n),
        .set      (acc_set),
        .clr      (acc_clr),
        .var_idx  (in_var),
        .pol      (in_pol),
        .map_nxt  (map_nxt),
        .pols_nxt (pols_nxt),
        .cnt_nxt  (cnt_nxt),
        .dup      (acc_dup),
        .conf     (acc_conf)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            w_en      <= 1'b0;
            wd        <= '0;
            pol_map   <= '0;
            unit_cnt  <= '0;
            conflict  <= 1'b0;
            last_seen <= 1'b0;
            clr_seen  <= 1'b0;
        end else begin
            w_en <= 1'b0;
            case (state)
                IDLE, COLLECT: begin
                    in_ready <= 1'b1;
                    if (xfer && acc_conf) begin
                        state     <= CONFLICT;
                        conflict  <= 1'b1;
                        last_seen <= in_last;
                        clr_seen  <= conflict_clr;
                        in_ready  <= !in_last;
                    end else if (xfer && in_last) begin
                        state    <= FLUSH;
                        in_ready <= 1'b0;
                        // a batch of only dropped beats produces no write
                        if (|map_nxt) begin
                            w_en     <= 1'b1;
                            wd       <= map_nxt;
                            pol_map  <= pols_nxt;
                            unit_cnt <= cnt_nxt;
                        end
                    end else if (xfer) begin
                        state <= COLLECT;
                    end
                end
                FLUSH: begin
                    state    <= w_en ? DRAIN : IDLE;
                    in_ready <= !w_en;
                end
                DRAIN: begin
                    if (uc_empty) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end
                end
                CONFLICT: begin
                    // after in_last, stall the next batch until the conflict is acknowledged
                    if (xfer && in_last) begin
                        last_seen <= 1'b1;
                        in_ready  <= 1'b0;
                    end
                    if (conflict_clr) clr_seen <= 1'b1;
                    if (conf_done) begin
                        state     <= IDLE;
                        conflict  <= 1'b0;
                        in_ready  <= 1'b1;
                        last_seen <= 1'b0;
                        clr_seen  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/unit_clause_collector.md
Name: unit_clause_collector

Overview:
- Write-side producer for the unit clause register.
- Accepts a stream of implied unit literals (variable index plus polarity) from the propagation logic and packs one batch into a W-bit variable bitmap plus a polarity map.
- Detects conflicting literals within a batch.
- Issues a single-cycle write (w_en/wd) to the unit clause register, then waits until the priority-encoder/delete path has drained that register before accepting the next batch.

Parameters:
- w, 8, number of variables (bitmap width).
- VW, $clog2(w), variable index width (derived; not overridable).

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  literal beat valid
- in_ready  output  1  collector can accept a beat
- in_var  input  VW  variable index of literal
- in_pol  input  1  literal polarity (1 = positive)
- in_last  input  1  final literal of batch
- uc_empty  input  1  unit clause register is all-zero (drained)
- w_en  output  1  write strobe to unit clause register
- wd  output  w  bitmap written (bit i = variable i is unit)
- pol_map  output  w  polarity of each set bit; valid while w_en=1 and held until next batch
- unit_cnt  output  VW+1  number of distinct variables in last flushed batch
- conflict  output  1  batch contained var with both polarities
- conflict_clr  input  1  acknowledge/clear conflict

Behaviour:
- Async reset (rst_n=0):
  - State=IDLE.
  - in_ready=0 during reset, 1 from the first edge after release.
  - w_en=0, wd=0, pol_map=0, unit_cnt=0, conflict=0.
  - Internal bitmaps and count cleared.
- Handshake: a beat transfers on a rising edge with in_valid && in_ready. in_ready is a registered/state decode with no combinational path from in_valid.
- States:
  - IDLE/COLLECT: in_ready=1.
    - On a transfer, set bit in_var in the accumulation bitmap and record in_pol.
    - If the bit was already set with the same polarity: duplicate, ignored, no count change.
    - If the bit was already set with the opposite polarity: go to CONFLICT.
    - Otherwise unit_cnt_acc += 1.
    - A transfer with in_last=1 (and no conflict) goes to FLUSH.
    - in_var >= w: beat accepted and dropped.
  - FLUSH (exactly 1 cycle):
    - w_en=1; wd=accumulated bitmap; pol_map and unit_cnt updated; in_ready=0.
    - Accumulators cleared.
    - Next state DRAIN. If the bitmap is all-zero (all beats dropped), skip the write (w_en stays 0) and return to IDLE.
  - DRAIN: in_ready=0; wait for uc_empty=1, sampled no earlier than the cycle after FLUSH; then go to IDLE.
  - CONFLICT:
    - conflict=1, registered in the same cycle the state is entered.
    - in_ready=1; beats are discarded until the in_last beat, including when the conflicting beat itself has in_last.
    - Accumulators cleared; no write is ever issued for a conflicting batch.
    - Stay in CONFLICT until conflict_clr=1 and the in_last beat has been consumed, then go to IDLE with conflict=0.
    - conflict_clr before in_last: remembered, and takes effect at in_last.
- Latency: w_en asserts the cycle after the in_last transfer.
- Single-beat batch (in_last on first beat): valid path, same 1-cycle latency.
- Simultaneous conflict and in_last on the same beat: CONFLICT wins; state exits on conflict_clr.
- Reset mid-batch or mid-DRAIN: all state discarded, no w_en.
- unit_cnt saturates at w. It cannot be exceeded because duplicates are not counted.

Decomposition:
- Shared package sat_pkg:
  - state enum typedef uc_coll_state_t {IDLE, COLLECT, FLUSH, DRAIN, CONFLICT}.
  - Default width constant W_VARS=8.
  - Literal struct {var, pol}.
- One natural sub-module: uc_accum, which holds the bitmap, polarity map and count, with set/clear ports and a combinational dup/conflict flag output.
- The top level holds the FSM and handshake.

Test Plan:
- Beats (3,+),(5,-),(0,+ last) → w_en pulse 1 cycle after last; wd=8'b0010_1001, pol_map=8'b0000_1001, unit_cnt=3; in_ready=0 until uc_empty=1.
- Beats (2,+),(2,+ last) → wd=8'b0000_0100, unit_cnt=1 (duplicate ignored).
- Beats (4,+),(4,- ),(1,+ last), conflict_clr pulse → conflict=1 from cycle after the second beat; no w_en; conflict=0 and IDLE after clr; next batch (7,+ last) → wd=8'b1000_0000.
- Flush then hold uc_empty=0 for 10 cycles → in_ready stays 0, in_valid beats are not accepted; uc_empty=1 → in_ready=1 next cycle.
- rst_n low asynchronously mid-batch after (6,-) → outputs zero immediately; next batch (1,+ last) → wd=8'b0000_0010 (no residue of var 6).
- Out-of-range var: with w=6, beat (7,+ last) → no w_en, return to IDLE.
